// File: rtl/vga_write_queue.sv
// vga_write_queue: buffers processor writes to the pointer/palette block and
// replays them as one-cycle commit strobes while the drain window is open.
// Optional feature: define VGA_WQ_VSYNC_GATE_EN to open the drain window only
// while VSync is low; otherwise the window is always open and VSync is ignored.
module vga_write_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [7:0]  ADDR_PORT   = 8'd40,
    parameter logic [7:0]  DATA_PORT   = 8'd41,
    parameter logic [7:0]  STATUS_PORT = 8'd3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Port_ID,
    input  logic [7:0] IN_DATA,
    input  logic       Write_Strobe,
    input  logic       Read_Strobe,
    input  logic       VSync,
    output logic [7:0] OUT_DATA,
    output logic [3:0] MemAddr,
    output logic [7:0] MemData,
    output logic       Write
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StDrain = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]    pend_addr_q, pend_addr_d;
    logic          overflow_q, overflow_d;
    logic [3:0]    mem_addr_q, mem_addr_d;
    logic [7:0]    mem_data_q, mem_data_d;
    logic          write_q, write_d;

    // Entry layout: {addr[3:0], data[7:0]}
    logic [11:0]   fifo_q [DEPTH];
    logic [11:0]   head;

    logic window_open;
    logic full, empty;
    logic push_req, push, ovf_set, pop;
    logic addr_wr, status_rd;
    logic [4:0] count5;

`ifdef VGA_WQ_VSYNC_GATE_EN
    assign window_open = ~VSync;
`else
    logic unused_vsync;
    assign unused_vsync = VSync;
    assign window_open  = 1'b1;
`endif

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign addr_wr   = Write_Strobe && (Port_ID == ADDR_PORT);
    assign push_req  = Write_Strobe && (Port_ID == DATA_PORT);
    // A full queue drops the push even if a pop frees a slot this cycle.
    assign push      = push_req && !full;
    assign ovf_set   = push_req && full;
    assign status_rd = Read_Strobe && (Port_ID == STATUS_PORT);
    assign head      = fifo_q[rd_ptr_q];
    assign count5    = 5'(count_q);

    // Drain FSM: entering DRAIN pops on the same edge to keep push-to-Write latency minimal.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (window_open && !empty) begin
                    state_d = StDrain;
                    pop     = 1'b1;
                end
            end
            StDrain: begin
                if (!window_open || empty) begin
                    state_d = StIdle;
                end else begin
                    pop = 1'b1;
                    if ((count_q == (AW + 1)'(1)) && !push) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Queue bookkeeping, pending address, sticky overflow and commit registers.
    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pend_addr_d = pend_addr_q;
        overflow_d  = overflow_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        write_d     = pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            mem_addr_d = head[11:8];
            mem_data_d = head[7:0];
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (addr_wr) begin
            pend_addr_d = IN_DATA[3:0];
        end

        // Set wins over a clearing status read in the same cycle.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (status_rd) begin
            overflow_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            pend_addr_q <= 4'hF;
            overflow_q  <= 1'b0;
            mem_addr_q  <= 4'hF;
            mem_data_q  <= 8'h00;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            pend_addr_q <= pend_addr_d;
            overflow_q  <= overflow_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            write_q     <= write_d;
        end
    end

    // Storage needs no reset: clearing the pointers and count discards its contents.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {pend_addr_q, IN_DATA};
        end
    end

    // Status byte is only driven during a qualified status read.
    always_comb begin
        OUT_DATA = 8'h00;
        if (status_rd) begin
            OUT_DATA = {full, empty, overflow_q, count5};
        end
    end

    assign MemAddr = mem_addr_q;
    assign MemData = mem_data_q;
    assign Write   = write_q;

endmodule

// File: tb/tb_vga_write_queue.sv
// Directed self-checking bench for vga_write_queue (default parameters).
// Gated scenarios build when VGA_WQ_VSYNC_GATE_EN is defined, ungated otherwise.
module tb_vga_write_queue;

    localparam logic [7:0] ADDR_P   = 8'd40;
    localparam logic [7:0] DATA_P   = 8'd41;
    localparam logic [7:0] STATUS_P = 8'd3;

    logic       clk;
    logic       rst;
    logic [7:0] port_id;
    logic [7:0] in_data;
    logic       write_strobe;
    logic       read_strobe;
    logic       vsync;
    logic [7:0] out_data;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       write;

    int vec_cnt = 0;
    int err_cnt = 0;

    vga_write_queue dut (
        .CLK          (clk),
        .RESET        (rst),
        .Port_ID      (port_id),
        .IN_DATA      (in_data),
        .Write_Strobe (write_strobe),
        .Read_Strobe  (read_strobe),
        .VSync        (vsync),
        .OUT_DATA     (out_data),
        .MemAddr      (mem_addr),
        .MemData      (mem_data),
        .Write        (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle processor write; call at a negedge, returns at the next negedge.
    task automatic wr_port(input logic [7:0] port, input logic [7:0] data);
        port_id      = port;
        in_data      = data;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = 8'h00;
    endtask

    // Combinational status peek that does not span a clock edge.
    task automatic read_status(output logic [7:0] v);
        read_strobe = 1'b1;
        port_id     = STATUS_P;
        #1;
        v           = out_data;
        read_strobe = 1'b0;
        port_id     = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] s;
        rst = 1'b1;
        #2;
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL reset_write: got %b want 0", write); end
        vec_cnt++; if (mem_addr !== 4'hF) begin err_cnt++; $display("FAIL reset_memaddr: got %h want f", mem_addr); end
        vec_cnt++; if (mem_data !== 8'h00) begin err_cnt++; $display("FAIL reset_memdata: got %h want 00", mem_data); end
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL reset_status: got %h want 40", s); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifndef VGA_WQ_VSYNC_GATE_EN
    task automatic test_basic();
        logic [7:0] s;
        wr_port(ADDR_P, 8'hF3);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL addr_no_push: got %b want 0", write); end
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL addr_status: got %h want 40", s); end
        wr_port(DATA_P, 8'hA5);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL push_latency: got %b want 0", write); end
        read_status(s);
        vec_cnt++; if (s !== 8'h01) begin err_cnt++; $display("FAIL count1_status: got %h want 01", s); end
        @(negedge clk);
        vec_cnt++; if (write !== 1'b1) begin err_cnt++; $display("FAIL commit_write: got %b want 1", write); end
        vec_cnt++; if (mem_addr !== 4'h3) begin err_cnt++; $display("FAIL commit_addr: got %h want 3", mem_addr); end
        vec_cnt++; if (mem_data !== 8'hA5) begin err_cnt++; $display("FAIL commit_data: got %h want a5", mem_data); end
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL drained_status: got %h want 40", s); end
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL one_cycle_write: got %b want 0", write); end
        vec_cnt++; if (mem_addr !== 4'h3) begin err_cnt++; $display("FAIL hold_addr: got %h want 3", mem_addr); end
        vec_cnt++; if (mem_data !== 8'hA5) begin err_cnt++; $display("FAIL hold_data: got %h want a5", mem_data); end
        read_strobe = 1'b1; port_id = 8'd4; #1;
        vec_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL wrong_port_read: got %h want 00", out_data); end
        read_strobe = 1'b0; port_id = STATUS_P; #1;
        vec_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL no_strobe_read: got %h want 00", out_data); end
        port_id = 8'h00;
        @(negedge clk);
        wr_port(8'd42, 8'h99);
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL other_port_push: got %b want 0", write); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        wr_port(ADDR_P, 8'h05);
        port_id      = DATA_P;
        write_strobe = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'h10 + 8'(i);
            @(negedge clk);
            if (i == 0) begin
                vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL b2b_first: got %b want 0", write); end
            end else begin
                vec_cnt++;
                if (write !== 1'b1 || mem_data !== 8'h10 + 8'(i - 1) || mem_addr !== 4'h5) begin
                    err_cnt++;
                    $display("FAIL b2b_stream[%0d]: got w=%b a=%h d=%h want w=1 a=5 d=%h",
                             i, write, mem_addr, mem_data, 8'h10 + 8'(i - 1));
                end
            end
        end
        write_strobe = 1'b0;
        port_id      = 8'h00;
        @(negedge clk);
        vec_cnt++; if (write !== 1'b1 || mem_data !== 8'h15) begin err_cnt++; $display("FAIL b2b_last: got w=%b d=%h want w=1 d=15", write, mem_data); end
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL b2b_end: got %b want 0", write); end
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL b2b_status: got %h want 40", s); end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] s;
        wr_port(ADDR_P, 8'h06);
        port_id      = DATA_P;
        write_strobe = 1'b1;
        in_data      = 8'h30;
        @(negedge clk);
        in_data      = 8'h31;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = 8'h00;
        vec_cnt++; if (write !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_write: got %b want 1", write); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL async_write_drop: got %b want 0", write); end
        vec_cnt++; if (mem_addr !== 4'hF || mem_data !== 8'h00) begin err_cnt++; $display("FAIL async_mem_reset: got a=%h d=%h want a=f d=00", mem_addr, mem_data); end
        @(negedge clk);
        rst = 1'b0;
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL reset_discard_status: got %h want 40", s); end
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL reset_no_replay: got %b want 0", write); end
        wr_port(DATA_P, 8'h77);
        @(negedge clk);
        vec_cnt++; if (write !== 1'b1 || mem_addr !== 4'hF || mem_data !== 8'h77) begin err_cnt++; $display("FAIL pend_reset_addr: got w=%b a=%h d=%h want w=1 a=f d=77", write, mem_addr, mem_data); end
        @(negedge clk);
    endtask
`else
    task automatic test_gated_basic();
        logic [7:0] s;
        vsync = 1'b1;
        wr_port(ADDR_P, 8'h03);
        wr_port(DATA_P, 8'hA5);
        wr_port(DATA_P, 8'h5A);
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL gated_hold: got %b want 0", write); end
        read_status(s);
        vec_cnt++; if (s !== 8'h02) begin err_cnt++; $display("FAIL gated_status: got %h want 02", s); end
        vsync = 1'b0;
        @(negedge clk);
        vec_cnt++; if (write !== 1'b1 || mem_addr !== 4'h3 || mem_data !== 8'hA5) begin err_cnt++; $display("FAIL gated_first: got w=%b a=%h d=%h want w=1 a=3 d=a5", write, mem_addr, mem_data); end
        @(negedge clk);
        vec_cnt++; if (write !== 1'b1 || mem_addr !== 4'h3 || mem_data !== 8'h5A) begin err_cnt++; $display("FAIL gated_second: got w=%b a=%h d=%h want w=1 a=3 d=5a", write, mem_addr, mem_data); end
        vsync = 1'b1;
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL gated_end: got %b want 0", write); end
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL gated_empty: got %h want 40", s); end
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        vsync = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_port(DATA_P, 8'(i));
        end
        read_status(s);
        vec_cnt++; if (s !== 8'hB0) begin err_cnt++; $display("FAIL ovf_status: got %h want b0", s); end
        read_strobe = 1'b1;
        port_id     = STATUS_P;
        @(negedge clk);
        read_strobe = 1'b0;
        port_id     = 8'h00;
        read_status(s);
        vec_cnt++; if (s !== 8'h90) begin err_cnt++; $display("FAIL ovf_clear: got %h want 90", s); end
        vsync = 1'b0;
        repeat (16) @(negedge clk);
        vec_cnt++; if (write !== 1'b1 || mem_data !== 8'h0F) begin err_cnt++; $display("FAIL ovf_last: got w=%b d=%h want w=1 d=0f", write, mem_data); end
        vsync = 1'b1;
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL ovf_dropped: got %b want 0", write); end
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL ovf_empty: got %h want 40", s); end
    endtask

    task automatic test_partial_window();
        logic [7:0] s;
        vsync = 1'b1;
        wr_port(ADDR_P, 8'h09);
        for (int i = 0; i < 8; i++) begin
            wr_port(DATA_P, 8'h20 + 8'(i));
        end
        vsync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (write !== 1'b1 || mem_addr !== 4'h9 || mem_data !== 8'h20 + 8'(i)) begin
                err_cnt++;
                $display("FAIL window_order[%0d]: got w=%b a=%h d=%h want w=1 a=9 d=%h",
                         i, write, mem_addr, mem_data, 8'h20 + 8'(i));
            end
            if (i == 2) begin
                vsync = 1'b1;
                @(negedge clk);
                vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL window_close: got %b want 0", write); end
                read_status(s);
                vec_cnt++; if (s !== 8'h05) begin err_cnt++; $display("FAIL window_count: got %h want 05", s); end
                @(negedge clk);
                vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL window_wait: got %b want 0", write); end
                vsync = 1'b0;
            end
        end
        vsync = 1'b1;
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL window_done: got %b want 0", write); end
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL window_empty: got %h want 40", s); end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] s;
        vsync = 1'b1;
        wr_port(ADDR_P, 8'h02);
        for (int i = 0; i < 6; i++) begin
            wr_port(DATA_P, 8'h40 + 8'(i));
        end
        vsync = 1'b0;
        @(negedge clk);
        vec_cnt++; if (write !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_write: got %b want 1", write); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL async_write_drop: got %b want 0", write); end
        @(negedge clk);
        rst = 1'b0;
        read_status(s);
        vec_cnt++; if (s !== 8'h40) begin err_cnt++; $display("FAIL reset_discard_status: got %h want 40", s); end
        vec_cnt++; if (mem_addr !== 4'hF) begin err_cnt++; $display("FAIL reset_memaddr_after: got %h want f", mem_addr); end
        @(negedge clk);
        vec_cnt++; if (write !== 1'b0) begin err_cnt++; $display("FAIL reset_no_replay: got %b want 0", write); end
        vsync = 1'b1;
    endtask
`endif

    initial begin
        rst          = 1'b1;
        port_id      = 8'h00;
        in_data      = 8'h00;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        vsync        = 1'b1;
        test_reset();
`ifndef VGA_WQ_VSYNC_GATE_EN
        test_basic();
        test_back_to_back();
        test_reset_mid_drain();
`else
        test_gated_basic();
        test_overflow();
        test_partial_window();
        test_reset_mid_drain();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_write_queue.md
VGA_WRITE_QUEUE -- requirements
Module: vga_write_queue

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4 to 64.
REQ-002 Parameter ADDR_PORT, default 8'd40, port ID that latches the pending palette/pointer address.
REQ-003 Parameter DATA_PORT, default 8'd41, port ID that pushes one write entry.
REQ-004 Parameter STATUS_PORT, default 8'd3, port ID of the readable status byte.
REQ-005 CLK  in  1  system clock; all registers rising-edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 Port_ID  in  8  processor port address.
REQ-008 IN_DATA  in  8  processor write data.
REQ-009 Write_Strobe  in  1  processor write qualifier, one cycle.
REQ-010 Read_Strobe  in  1  processor read qualifier, one cycle.
REQ-011 VSync  in  1  vertical sync from the sync counters, active-low pulse marking the drain window.
REQ-012 OUT_DATA  out  8  status byte, combinational.
REQ-013 MemAddr  out  4  registered address to the pointer block.
REQ-014 MemData  out  8  registered data to the pointer block.
REQ-015 Write  out  1  registered one-cycle commit strobe to the pointer block.

Function
REQ-016 Write_Strobe with Port_ID==ADDR_PORT SHALL load PendAddr<=IN_DATA[3:0]; no push occurs.
REQ-017 Write_Strobe with Port_ID==DATA_PORT SHALL push {PendAddr, IN_DATA} when count<DEPTH; PendAddr is unchanged, so consecutive data writes reuse it.
REQ-018 A push while count==DEPTH SHALL be dropped and set sticky Overflow, even if a pop occurs in the same cycle.
REQ-019 FSM states IDLE and DRAIN: IDLE->DRAIN when drain window open and count>0; DRAIN->IDLE when count reaches 0 after a pop or the window closes.
REQ-020 In DRAIN, each cycle SHALL pop the head entry; on the next edge MemAddr/MemData take the entry and Write=1 for exactly that cycle.
REQ-021 Push-to-Write latency SHALL be 2 cycles minimum: push at edge N, pop at edge N+1, Write high in cycle after N+1.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-023 Window closing mid-drain SHALL stop pops at the next edge; remaining entries wait for the next window; no entry is lost or duplicated.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-025 OUT_DATA SHALL be {Full, Empty, Overflow, count[4:0] zero-extended/truncated} when Read_Strobe and Port_ID==STATUS_PORT, else 8'h00.
REQ-026 A status read SHALL clear Overflow at that edge, unless an overflow occurs in the same cycle (set wins).
REQ-027 MemAddr/MemData SHALL hold their last values when Write==0.

Reset
REQ-028 RESET high SHALL immediately force: state IDLE, count 0, pointers 0, PendAddr 4'hF, MemAddr 4'hF, MemData 8'h00, Write 0, Overflow 0.
REQ-029 RESET asserted mid-drain SHALL drop Write asynchronously and discard all queued entries.

Configuration
REQ-030 Macro VGA_WQ_VSYNC_GATE_EN defined: drain window open only while VSync==0.
REQ-031 VGA_WQ_VSYNC_GATE_EN undefined: drain window permanently open; entries drain whenever count>0, VSync ignored.

Verification
REQ-032 Gated, VSync=1: ADDR 4'h3, DATA 8'hA5, DATA 8'h5A -> no Write, status 8'h02; VSync->0 -> two Write pulses (3,A5) then (3,5A) on consecutive cycles, status 8'h40.
REQ-033 Gated, VSync=1: 17 data pushes with DEPTH=16 -> status 8'hB0 (Full, Overflow, count 16); status read -> next read 8'h90.
REQ-034 Gated: 8 entries queued, VSync low for 3 cycles -> exactly 3 Writes, count 5; next low window -> remaining 5 in order.
REQ-035 Ungated: push during an active drain each cycle -> count constant, Write continuous, order preserved.
REQ-036 RESET pulsed during drain with 6 entries queued -> Write 0 same cycle, status 8'h40, MemAddr 4'hF after release.
